// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative multdiv unit: latches a request, fires a
// one-cycle start pulse, waits for ready under a timeout and returns a write-back packet.
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_Mult,
    output logic        md_ctrl_Div,
    input  logic [31:0] md_result,
    input  logic        md_except,
    input  logic        md_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_except,
    output logic        wb_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      opa_q, opa_d, opb_q, opb_d;
    logic             mult_q, mult_d, div_q, div_d;
    logic             wbv_q, wbv_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_exc_q, wb_exc_d;
    logic             wb_to_q, wb_to_d;

    // Saturating increment so the counter can never wrap back below the limit.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and write-back packet computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        mult_d    = 1'b0;
        div_d     = 1'b0;
        wbv_d     = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_exc_d  = wb_exc_q;
        wb_to_d   = wb_to_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    state_d = ST_ISSUE;
                    rd_d    = req_rd;
                    opa_d   = req_a;
                    opb_d   = req_b;
                    mult_d  = !req_op;
                    div_d   = req_op;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_ready) begin
                    state_d   = ST_DONE;
                    wbv_d     = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = md_result;
                    wb_exc_d  = md_except;
                    wb_to_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d   = ST_DONE;
                        wbv_d     = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = '0;
                        wb_exc_d  = 1'b1;
                        wb_to_d   = 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            wbv_q     <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
            wb_to_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            wbv_q     <= wbv_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            wb_to_q   <= wb_to_d;
        end
    end

    // A flush arriving in the write-back cycle still cancels the strobe.
    assign wb_valid = wbv_q & ~flush;

    assign stall = resetn & ((state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                             ((state_q == ST_IDLE) && req_valid && !flush));

    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_ctrl_Mult = mult_q;
    assign md_ctrl_Div  = div_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_except    = wb_exc_q;
    assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_multdiv_issue_ctrl;

    localparam int TO = 100;

    logic        clock = 1'b0;
    logic        resetn, req_valid, req_op, flush, md_except, md_ready;
    logic [31:0] req_a, req_b, md_result;
    logic [4:0]  req_rd;
    logic        stall, md_ctrl_Mult, md_ctrl_Div, wb_valid, wb_except, wb_timeout;
    logic [31:0] md_operandA, md_operandB, wb_data;
    logic [4:0]  wb_rd;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush), .stall(stall),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_Mult(md_ctrl_Mult), .md_ctrl_Div(md_ctrl_Div),
        .md_result(md_result), .md_except(md_except), .md_ready(md_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_except(wb_except), .wb_timeout(wb_timeout)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an op is a span of cycles measured from its acceptance.
    bit          m_busy = 0, m_done = 0;
    int          m_t = 0;
    logic [4:0]  m_rd = '0, e_wbrd = '0;
    logic [31:0] e_opa = '0, e_opb = '0, e_wbd = '0;
    bit          e_mult = 0, e_div = 0, e_wbe = 0, e_wbt = 0;
    bit          o_wbv, o_mult, o_div;

    task automatic model_edge();
        if (!resetn) begin
            m_busy = 0; m_done = 0; m_t = 0; m_rd = '0;
            e_opa = '0; e_opb = '0; e_mult = 0; e_div = 0;
            e_wbd = '0; e_wbe = 0; e_wbt = 0; e_wbrd = '0;
        end else begin
            e_mult = 0; e_div = 0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (req_valid && !flush) begin
                    m_busy = 1; m_t = 1; m_rd = req_rd;
                    e_opa = req_a; e_opb = req_b;
                    e_mult = !req_op; e_div = req_op;
                end
            end else if (flush) begin
                m_busy = 0;
            end else if (m_t >= 2 && md_ready) begin
                m_busy = 0; m_done = 1;
                e_wbd = md_result; e_wbe = md_except; e_wbt = 0; e_wbrd = m_rd;
            end else if (m_t >= 2 && m_t - 1 == TO) begin
                m_busy = 0; m_done = 1;
                e_wbd = '0; e_wbe = 1; e_wbt = 1; e_wbrd = m_rd;
            end else begin
                m_t++;
            end
        end
    endtask

    // Called at a falling edge with inputs already applied; ends at the next falling edge.
    task automatic cycle();
        bit exp_stall;
        #1;
        exp_stall = resetn && (m_busy || (!m_done && req_valid && !flush));
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("wb_valid", 32'(wb_valid), 32'(m_done && !flush));
        chk("ctrl_mult", 32'(md_ctrl_Mult), 32'(e_mult));
        chk("ctrl_div", 32'(md_ctrl_Div), 32'(e_div));
        chk("operandA", md_operandA, e_opa);
        chk("operandB", md_operandB, e_opb);
        chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
        chk("wb_data", wb_data, e_wbd);
        chk("wb_except", 32'(wb_except), 32'(e_wbe));
        chk("wb_timeout", 32'(wb_timeout), 32'(e_wbt));
        o_wbv = wb_valid; o_mult = md_ctrl_Mult; o_div = md_ctrl_Div;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic quiet();
        resetn = 1; req_valid = 0; flush = 0; md_ready = 0;
    endtask

    int wb_cyc, p_cyc, mp, dp;

    // One request at relative cycle 0, then a fixed window of ncyc cycles.
    task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int ready_at, input logic [31:0] res,
                          input bit exc, input int flush_at, input int rst_at, input int ncyc);
        wb_cyc = -1; p_cyc = -1; mp = 0; dp = 0;
        req_op = op; req_a = a; req_b = b; req_rd = rd; md_result = res; md_except = exc;
        for (int c = 0; c < ncyc; c++) begin
            quiet();
            req_valid = (c == 0);
            md_ready  = (c == ready_at);
            flush     = (c == flush_at);
            resetn    = (c != rst_at);
            cycle();
            if (o_wbv && wb_cyc < 0) wb_cyc = c;
            if ((o_mult || o_div) && p_cyc < 0) p_cyc = c;
            mp += int'(o_mult);
            dp += int'(o_div);
        end
    endtask

    typedef struct {
        logic rv, op, fl, rdy, exc;
        logic [31:0] a, b, res;
        logic [4:0] rd;
        logic e_stall, e_mult, e_div, e_wbv, e_exc;
        logic [31:0] e_data;
        logic [4:0] e_rd;
    } vec_t;

    function automatic vec_t mkv(input int rv, input int op, input int a, input int b,
                                 input int rd, input int fl, input int rdy, input int res,
                                 input int exc, input int st, input int m, input int d,
                                 input int v, input int data, input int e, input int erd);
        vec_t x;
        x.rv = 1'(rv); x.op = 1'(op); x.a = 32'(a); x.b = 32'(b); x.rd = 5'(rd);
        x.fl = 1'(fl); x.rdy = 1'(rdy); x.res = 32'(res); x.exc = 1'(exc);
        x.e_stall = 1'(st); x.e_mult = 1'(m); x.e_div = 1'(d); x.e_wbv = 1'(v);
        x.e_data = 32'(data); x.e_exc = 1'(e); x.e_rd = 5'(erd);
        return x;
    endfunction

    vec_t tbl[12];

    initial begin
        //               rv op a  b rd fl rdy res exc | st m d v data e rd
        tbl[0]  = mkv(1, 0, 7, 3, 5, 0, 0, 0,  0,  1, 0, 0, 0, 0,  0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0,  0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0,  0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 1, 21, 0,  1, 0, 0, 0, 0,  0, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 21, 0, 5);
        tbl[5]  = mkv(1, 1, 7, 0, 9, 0, 0, 0,  0,  1, 0, 0, 0, 21, 0, 5);
        tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 0, 1, 0, 21, 0, 5);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 1, 0,  1,  1, 0, 0, 0, 21, 0, 5);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0,  1, 9);
        tbl[9]  = mkv(1, 0, 4, 4, 3, 1, 0, 0,  0,  0, 0, 0, 0, 0,  1, 9);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1, 85, 0,  0, 0, 0, 0, 0,  1, 9);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 9);

        resetn = 0; req_valid = 0; req_op = 0; req_a = '0; req_b = '0; req_rd = '0;
        flush = 0; md_result = '0; md_except = 0; md_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cycle();
        quiet();

        // Directed cycle-by-cycle table
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].rv; req_op = tbl[i].op; req_a = tbl[i].a; req_b = tbl[i].b;
            req_rd = tbl[i].rd; flush = tbl[i].fl; md_ready = tbl[i].rdy;
            md_result = tbl[i].res; md_except = tbl[i].exc;
            #1;
            chk("tbl_stall", 32'(stall), 32'(tbl[i].e_stall));
            chk("tbl_mult", 32'(md_ctrl_Mult), 32'(tbl[i].e_mult));
            chk("tbl_div", 32'(md_ctrl_Div), 32'(tbl[i].e_div));
            chk("tbl_wb_valid", 32'(wb_valid), 32'(tbl[i].e_wbv));
            chk("tbl_wb_data", wb_data, tbl[i].e_data);
            chk("tbl_wb_except", 32'(wb_except), 32'(tbl[i].e_exc));
            chk("tbl_wb_rd", 32'(wb_rd), 32'(tbl[i].e_rd));
            cycle();
        end
        quiet();

        // Multiply 7*3, ready 32 cycles after the start pulse
        run_op(0, 32'd7, 32'd3, 5'd17, 33, 32'd21, 0, -1, -1, 40);
        chk("mul_wb_cycle", 32'(wb_cyc), 32'd34);
        chk("mul_pulse_cycle", 32'(p_cyc), 32'd1);
        chk("mul_mult_pulses", 32'(mp), 32'd1);
        chk("mul_div_pulses", 32'(dp), 32'd0);
        chk("mul_data", wb_data, 32'd21);
        chk("mul_rd", 32'(wb_rd), 32'd17);

        // Divide 2 / -5 returns 0
        run_op(1, 32'd2, 32'hFFFF_FFFB, 5'd4, 7, 32'd0, 0, -1, -1, 12);
        chk("div_wb_cycle", 32'(wb_cyc), 32'd8);
        chk("div_div_pulses", 32'(dp), 32'd1);
        chk("div_data", wb_data, 32'd0);

        // Divide by zero reports the unit's exception
        run_op(1, 32'd7, 32'd0, 5'd6, 3, 32'd0, 1, -1, -1, 8);
        chk("dbz_except", 32'(wb_except), 32'd1);
        chk("dbz_timeout", 32'(wb_timeout), 32'd0);

        // Timeout with ready never high, then next request on the first IDLE cycle
        run_op(0, 32'd11, 32'd13, 5'd2, -1, 32'hDEAD_BEEF, 0, -1, -1, 103);
        chk("to_wb_cycle", 32'(wb_cyc), 32'd102);
        chk("to_data", wb_data, 32'd0);
        chk("to_except", 32'(wb_except), 32'd1);
        chk("to_timeout", 32'(wb_timeout), 32'd1);
        run_op(1, 32'd9, 32'd3, 5'd8, 4, 32'd3, 0, -1, -1, 8);
        chk("after_to_pulse_cycle", 32'(p_cyc), 32'd1);
        chk("after_to_wb_cycle", 32'(wb_cyc), 32'd5);

        // Flush on WAIT cycle 5 collides with ready: flush wins
        run_op(0, 32'd5, 32'd5, 5'd10, 6, 32'd25, 0, 6, -1, 12);
        chk("flush_no_wb", 32'(wb_cyc), 32'hFFFF_FFFF);
        run_op(0, 32'd6, 32'd6, 5'd11, 2, 32'd36, 0, -1, -1, 6);
        chk("post_flush_wb_cycle", 32'(wb_cyc), 32'd3);
        chk("post_flush_data", wb_data, 32'd36);

        // Reset mid-WAIT, late ready arrives in IDLE
        run_op(1, 32'd8, 32'd2, 5'd12, 9, 32'd4, 0, -1, 5, 14);
        chk("rst_no_wb", 32'(wb_cyc), 32'hFFFF_FFFF);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_operandA", md_operandA, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            resetn    = ($urandom_range(0, 99) != 0);
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 1'($urandom_range(0, 1));
            req_a     = $urandom;
            req_b     = $urandom;
            req_rd    = 5'($urandom_range(0, 31));
            flush     = ($urandom_range(0, 15) == 0);
            md_ready  = ($urandom_range(0, 5) == 0);
            md_result = $urandom;
            md_except = ($urandom_range(0, 3) == 0);
            cycle();
        end
        quiet();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
